// File: rtl/maincontroller_pkg.sv
// Shared encodings for the main controller: opcodes, execution-unit control,
// FSM states, overflow policies and the registered strobe bundle.
package maincontroller_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_ADD   = 2'b10,
      OP_SUB   = 2'b11
   } op_e;

   localparam logic [1:0] DIR_EXE_IDLE   = 2'b00;
   localparam logic [1:0] DIR_EXE_LOAD_A = 2'b01;
   localparam logic [1:0] DIR_EXE_LOAD_B = 2'b10;
   localparam logic [1:0] DIR_EXE_RESULT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_SRC1,
      ST_SRC2,
      ST_EXEC,
      ST_WB,
      ST_FIN
   } state_e;

   localparam int unsigned OV_WRITE_FLAG    = 0;
   localparam int unsigned OV_SUPPRESS_FLAG = 1;

   typedef struct packed {
      logic       wr;
      logic       dir_sram;
      logic [1:0] dir_exe;
      logic       op_alu;
      logic       busy;
      logic       done;
   } strobe_t;

endpackage

// File: rtl/maincontroller_p.sv
// Main controller: sequences one instruction at a time into SRAM and ALU control
// strobes. Outputs are Moore values registered from the next state.
module maincontroller_p
   import maincontroller_pkg::*;
#(
   parameter int unsigned ADDR_W    = 3,
   parameter int unsigned DATA_W    = 4,
   parameter int unsigned OV_POLICY = 1,
   localparam int unsigned INST_W   = 2 + 3*ADDR_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              EN,
   input  logic [INST_W-1:0] Inst,
   input  logic              OV,
   output logic              WR,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] Data,
   output logic              DIR_SRAM,
   output logic [1:0]        DIR_EXE,
   output logic              OP_ALU,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   if (DATA_W > 2*ADDR_W) begin : g_bad_width
      $error("maincontroller_p: DATA_W must not exceed 2*ADDR_W");
   end

   localparam logic SUPPRESS_ON_OV = 1'(OV_POLICY == OV_SUPPRESS_FLAG);

   state_e            state_q, state_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              err_d;
   strobe_t           strb_q, strb_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d;

   op_e               op_d;
   logic [ADDR_W-1:0] dest_d, src1_d, src2_d;
   logic [DATA_W-1:0] imm_d;

   // Instruction fields of the instruction that will be current next cycle
   always_comb begin
      op_d   = op_e'(inst_d[INST_W-1 -: 2]);
      dest_d = inst_d[3*ADDR_W-1 -: ADDR_W];
      src1_d = inst_d[2*ADDR_W-1 -: ADDR_W];
      src2_d = inst_d[ADDR_W-1:0];
      imm_d  = inst_d[DATA_W-1:0];
   end

   // Next state, instruction latch and overflow capture
   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      err_d   = ERR;
      case (state_q)
         ST_IDLE: begin
            if (EN) begin
               inst_d = Inst;
               err_d  = 1'b0;
               case (op_e'(Inst[INST_W-1 -: 2]))
                  OP_READ:  state_d = ST_READ;
                  OP_WRITE: state_d = ST_WRITE;
                  default:  state_d = ST_SRC1;
               endcase
            end
         end
         ST_READ:  state_d = ST_FIN;
         ST_WRITE: state_d = ST_FIN;
         ST_SRC1:  state_d = ST_SRC2;
         ST_SRC2:  state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_WB;
            if (OV) begin
               err_d = 1'b1;
            end
         end
         ST_WB:    state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Moore decode of the upcoming state; WB only follows EXEC, so OV here is the captured value
   always_comb begin
      strb_d      = '0;
      addr_d      = '0;
      data_d      = '0;
      strb_d.busy = (state_d != ST_IDLE);
      case (state_d)
         ST_READ: begin
            addr_d = dest_d;
         end
         ST_WRITE: begin
            strb_d.wr       = 1'b1;
            strb_d.dir_sram = 1'b0;
            addr_d          = dest_d;
            data_d          = imm_d;
         end
         ST_SRC1: begin
            addr_d         = src1_d;
            strb_d.dir_exe = DIR_EXE_LOAD_A;
         end
         ST_SRC2: begin
            addr_d         = src2_d;
            strb_d.dir_exe = DIR_EXE_LOAD_B;
         end
         ST_EXEC: begin
            strb_d.dir_exe = DIR_EXE_RESULT;
            strb_d.op_alu  = op_d[0];
         end
         ST_WB: begin
            addr_d          = dest_d;
            strb_d.dir_sram = 1'b1;
            strb_d.dir_exe  = DIR_EXE_RESULT;
            strb_d.op_alu   = op_d[0];
            strb_d.wr       = !(SUPPRESS_ON_OV && OV);
         end
         ST_FIN: begin
            strb_d.done = 1'b1;
         end
         default: begin
            strb_d.busy = 1'b0;
         end
      endcase
   end

   // State, instruction register, error flag and output registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         inst_q  <= '0;
         ERR     <= 1'b0;
         strb_q  <= '0;
         ADDR    <= '0;
         Data    <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         ERR     <= err_d;
         strb_q  <= strb_d;
         ADDR    <= addr_d;
         Data    <= data_d;
      end
   end

   assign WR       = strb_q.wr;
   assign DIR_SRAM = strb_q.dir_sram;
   assign DIR_EXE  = strb_q.dir_exe;
   assign OP_ALU   = strb_q.op_alu;
   assign BUSY     = strb_q.busy;
   assign DONE     = strb_q.done;

endmodule

// File: tb/tb_maincontroller_p.sv
// Bench for maincontroller_p: one instance per overflow policy on shared stimulus,
// checked cycle by cycle against an expected output trace built from the op rules.
module tb_maincontroller_p;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 4;
   localparam int unsigned IW = 2 + 3*AW;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          dir_sram;
      logic [1:0]    dir_exe;
      logic          op_alu;
      logic          busy;
      logic          done;
      logic          err;
   } obs_t;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          EN;
   logic [IW-1:0] Inst;
   logic          OV;

   logic          wr_s, dir_sram_s, op_alu_s, busy_s, done_s, err_s;
   logic [AW-1:0] addr_s;
   logic [DW-1:0] data_s;
   logic [1:0]    dir_exe_s;
   logic          wr_w, dir_sram_w, op_alu_w, busy_w, done_w, err_w;
   logic [AW-1:0] addr_w;
   logic [DW-1:0] data_w;
   logic [1:0]    dir_exe_w;

   obs_t obs_sup, obs_wb;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   maincontroller_p #(.ADDR_W(AW), .DATA_W(DW), .OV_POLICY(1)) u_dut_sup (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .Inst(Inst), .OV(OV),
      .WR(wr_s), .ADDR(addr_s), .Data(data_s), .DIR_SRAM(dir_sram_s),
      .DIR_EXE(dir_exe_s), .OP_ALU(op_alu_s), .BUSY(busy_s), .DONE(done_s),
      .ERR(err_s)
   );

   maincontroller_p #(.ADDR_W(AW), .DATA_W(DW), .OV_POLICY(0)) u_dut_wb (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .Inst(Inst), .OV(OV),
      .WR(wr_w), .ADDR(addr_w), .Data(data_w), .DIR_SRAM(dir_sram_w),
      .DIR_EXE(dir_exe_w), .OP_ALU(op_alu_w), .BUSY(busy_w), .DONE(done_w),
      .ERR(err_w)
   );

   assign obs_sup = {wr_s, addr_s, data_s, dir_sram_s, dir_exe_s, op_alu_s, busy_s, done_s, err_s};
   assign obs_wb  = {wr_w, addr_w, data_w, dir_sram_w, dir_exe_w, op_alu_w, busy_w, done_w, err_w};

   task automatic check(input string tag, input obs_t got, input obs_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected per-cycle outputs from the accept edge through the following IDLE cycle
   task automatic build(input logic [IW-1:0] inst, input logic ov, input bit suppress,
                        output obs_t seq[6], output int len);
      logic [1:0]    op;
      logic [AW-1:0] dest, s1, s2;
      logic [DW-1:0] imm;
      obs_t o;
      op   = inst[IW-1 -: 2];
      dest = inst[3*AW-1 -: AW];
      s1   = inst[2*AW-1 -: AW];
      s2   = inst[AW-1:0];
      imm  = inst[DW-1:0];
      for (int i = 0; i < 6; i++) seq[i] = '0;
      if (op[1] == 1'b0) begin
         o = '0; o.busy = 1'b1; o.addr = dest;
         if (op[0]) begin
            o.wr = 1'b1; o.data = imm;
         end
         seq[0] = o;
         o = '0; o.busy = 1'b1; o.done = 1'b1;
         seq[1] = o;
         seq[2] = '0;
         len = 3;
      end else begin
         o = '0; o.busy = 1'b1; o.addr = s1; o.dir_exe = 2'b01;
         seq[0] = o;
         o = '0; o.busy = 1'b1; o.addr = s2; o.dir_exe = 2'b10;
         seq[1] = o;
         o = '0; o.busy = 1'b1; o.dir_exe = 2'b11; o.op_alu = op[0];
         seq[2] = o;
         o = '0; o.busy = 1'b1; o.addr = dest; o.dir_sram = 1'b1; o.dir_exe = 2'b11;
         o.op_alu = op[0]; o.wr = !(suppress && ov); o.err = ov;
         seq[3] = o;
         o = '0; o.busy = 1'b1; o.done = 1'b1; o.err = ov;
         seq[4] = o;
         o = '0; o.err = ov;
         seq[5] = o;
         len = 6;
      end
   endtask

   // Issue one instruction from an IDLE cycle and check every cycle up to the next IDLE
   task automatic run_instr(input string tag, input logic [IW-1:0] inst, input logic ov,
                            input bit hold);
      obs_t es[6];
      obs_t ew[6];
      int   n;
      build(inst, ov, 1'b1, es, n);
      build(inst, ov, 1'b0, ew, n);
      EN   = 1'b1;
      Inst = inst;
      @(posedge CLK); #1;
      for (int k = 0; k < n; k++) begin
         if (k < n-1) EN = hold ? 1'b1 : 1'($urandom);
         else         EN = 1'b0;
         Inst = IW'($urandom);
         OV   = (inst[IW-1] && k == 2) ? ov : 1'($urandom);
         @(negedge CLK);
         check($sformatf("%s_sup[%0d]", tag, k), obs_sup, es[k]);
         check($sformatf("%s_wb[%0d]", tag, k), obs_wb, ew[k]);
         if (k < n-1) begin
            @(posedge CLK); #1;
         end
      end
   endtask

   initial begin
      obs_t o;
      RST_N = 1'b0;
      EN    = 1'b0;
      Inst  = '0;
      OV    = 1'b0;

      repeat (2) @(posedge CLK);
      #1;
      check("reset_sup", obs_sup, '0);
      check("reset_wb", obs_wb, '0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("idle_sup", obs_sup, '0);
      check("idle_wb", obs_wb, '0);

      run_instr("write", 11'b01_010_001_111, 1'b0, 1'b0);
      run_instr("add", 11'b10_101_001_011, 1'b0, 1'b0);
      run_instr("sub_ov", 11'b11_111_011_101, 1'b1, 1'b0);
      run_instr("read_after_ov", 11'b00_110_000_000, 1'b1, 1'b0);
      run_instr("sub_ov2", 11'b11_111_011_101, 1'b1, 1'b1);
      run_instr("add_hold", 11'b10_011_100_110, 1'b0, 1'b1);
      run_instr("write_hold", 11'b01_001_110_010, 1'b0, 1'b1);

      // Asynchronous reset in the SRC2 cycle of an ADD
      EN   = 1'b1;
      Inst = 11'b10_101_001_011;
      @(posedge CLK); #1;
      EN = 1'b0;
      @(posedge CLK); #1;
      @(negedge CLK);
      o = '0; o.busy = 1'b1; o.addr = 3'b011; o.dir_exe = 2'b10;
      check("src2_sup", obs_sup, o);
      check("src2_wb", obs_wb, o);
      #1 RST_N = 1'b0;
      #1;
      check("async_rst_sup", obs_sup, '0);
      check("async_rst_wb", obs_wb, '0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("post_rst_sup", obs_sup, '0);
      check("post_rst_wb", obs_wb, '0);

      for (int i = 0; i < 40; i++) begin
         run_instr($sformatf("rnd%0d", i), IW'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/maincontroller_p.md
# maincontroller_p

Parametrised next-generation main controller. Sequences one instruction at a time into SRAM read/write, operand fetch and ALU execute/write-back control strokes, with an explicit start/busy/done handshake and a configurable overflow policy. Sits between the instruction source and the SRAM/execution datapath, driving the same control strobes as the current controller at generic address/data widths.

## Interface

Parameters
- ADDR_W, 3: SRAM address width.
- DATA_W, 4: data width. Must satisfy DATA_W <= 2*ADDR_W.
- OV_POLICY, 1:
  - 0 = write back the result on overflow and flag it.
  - 1 = suppress the write-back on overflow and flag it.
- INST_W (localparam) = 2 + 3*ADDR_W.
  - Field layout, MSB first: op[1:0] | dest | src1 | src2.
  - Immediate = Inst[DATA_W-1:0].

Ports (one clock; reset is asynchronous and active-low)
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  start request; sampled only in IDLE.
- Inst  in  INST_W  instruction; latched when EN is accepted.
- OV  in  1  ALU overflow; sampled only in EXEC.
- WR  out  1  SRAM write strobe.
- ADDR  out  ADDR_W  SRAM address.
- Data  out  DATA_W  immediate write data.
- DIR_SRAM  out  1  SRAM write-data source: 0 = Data, 1 = ALU result.
- DIR_EXE  out  2  execution-unit control: 00 idle, 01 load A, 10 load B, 11 drive result.
- OP_ALU  out  1  ALU operation: 0 = add, 1 = subtract.
- BUSY  out  1  instruction in progress.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky overflow flag.

## Operation

- Opcodes:
  - 00 READ: ADDR = dest.
  - 01 WRITE: mem[dest] = imm.
  - 10 ADD: mem[dest] = mem[src1] + mem[src2].
  - 11 SUB: mem[dest] = mem[src1] - mem[src2].
- States: IDLE, READ, WRITE, SRC1, SRC2, EXEC, WB, FIN.
- Transitions:
  - IDLE -> READ / WRITE / SRC1 on EN=1, selected by op. Inst is latched and ERR is cleared.
  - READ -> FIN.
  - WRITE -> FIN.
  - SRC1 -> SRC2 -> EXEC -> WB -> FIN.
  - FIN -> IDLE.
- Outputs are Moore, decoded from state and the latched Inst. Any output not listed below is 0.
  - READ: ADDR=dest.
  - WRITE: WR=1, ADDR=dest, Data=imm, DIR_SRAM=0.
  - SRC1: ADDR=src1, DIR_EXE=01.
  - SRC2: ADDR=src2, DIR_EXE=10.
  - EXEC: DIR_EXE=11, OP_ALU=op[0]. OV is captured at the end of this cycle.
  - WB: ADDR=dest, DIR_SRAM=1, DIR_EXE=11, OP_ALU=op[0]. WR=1 unless (OV_POLICY=1 and OV was captured); in that case WR=0.
  - FIN: DONE=1.
- BUSY = 1 in every state except IDLE.
- ERR is set at the EXEC->WB edge when OV=1. It holds until the next accepted EN.
- EN while BUSY is ignored. Changes to Inst while BUSY have no effect.
- EN held high in FIN does not start a new instruction until the cycle after FIN, i.e. the next IDLE.
- Arithmetic is performed by the external ALU. The controller performs no width arithmetic.

## Timing

- Reset (asynchronous, RST_N=0): state=IDLE and every output is 0 immediately.
  - A write in progress is dropped: WR falls immediately.
  - ERR is cleared.
- From the EN-accept edge to the DONE cycle:
  - READ/WRITE: DONE in the 2nd cycle.
  - ADD/SUB: DONE in the 5th cycle.
- Back-to-back issue: the earliest next accept is the first IDLE cycle after FIN.
  - Throughput: 3 cycles per READ/WRITE, 6 cycles per ADD/SUB.
- ADDR, Data and the strobes are stable for the whole state cycle.

## Structure

- Shared package maincontroller_pkg:
  - op encodings: OP_READ, OP_WRITE, OP_ADD, OP_SUB.
  - DIR_EXE encodings.
  - state enum.
  - OV_POLICY constants.
- No sub-module. The block is a single FSM with an instruction register and an ERR/OV capture register.

## Test plan

- Reset: RST_N low mid-ADD in SRC2 -> all outputs 0 that cycle. After release: IDLE, BUSY=0, no WR.
- WRITE: Inst=01_010_001_111, EN=1 -> the next cycle has WR=1, ADDR=010, Data=1111, DIR_SRAM=0; DONE pulses the cycle after.
- ADD: Inst=10_101_001_011 with OV=0 -> the sequence is:
  - ADDR=001/DIR_EXE=01,
  - ADDR=011/DIR_EXE=10,
  - DIR_EXE=11/OP_ALU=0,
  - WR=1/ADDR=101/DIR_SRAM=1,
  - DONE.
  - ERR stays 0.
- SUB with overflow: Inst=11_111_011_101, OV=1 during EXEC, OV_POLICY=1 -> OP_ALU=1, WB has WR=0, ERR=1 after WB. ERR clears on the next accepted EN.
- OV_POLICY=0, same stimulus -> WB has WR=1, ADDR=111 and ERR=1.
- EN held high with new Inst values throughout an ADD -> the ADD completes unchanged; the next instruction starts only after FIN, with no overlap.
